// File: rtl/mem_interface_unit_if.sv
// Byte-wide main-memory request/response bus between the memory interface unit
// (master) and main memory (slave).
interface mem_interface_unit_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_resp;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_interface_unit.sv
// Load/store responder for the instruction unit: runs one request at a time on the
// byte-wide memory bus. Optional per-transaction timeout under `MIU_TIMEOUT_EN.
module mem_interface_unit #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8
`ifdef MIU_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic                store,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [2*DATA_W-1:0] result,
  output logic [DATA_W-1:0]   data,
  output logic                mem_done,
  output logic                mem_err,
  mem_interface_unit_if.master mem
);

  typedef enum logic [2:0] {
    IDLE,
    LD,
    ST_LO,
    ST_GAP,
    ST_HI,
    DONE
  } state_t;

  state_t            state_q, state_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic              done_q, done_n;
  logic              req_q, req_n;
  logic              we_q, we_n;
  logic [ADDR_W-1:0] maddr_q, maddr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic [DATA_W-1:0] hi_q, hi_n;
  logic              timeout;

`ifdef MIU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Counter is held clear while mem_req is low, so it restarts on every rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (!req_q) begin
      cnt_q <= '0;
    end else if (!mem.mem_resp) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout = req_q && !mem.mem_resp && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // mem_req is high only in LD/ST_LO/ST_HI, so timeout alone marks an aborted access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout;
    end
  end

  assign mem_err = err_q;
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    data_n  = data_q;
    done_n  = 1'b0;
    req_n   = req_q;
    we_n    = we_q;
    maddr_n = maddr_q;
    wdata_n = wdata_q;
    hi_n    = hi_q;
    unique case (state_q)
      IDLE: begin
        if (store) begin
          req_n   = 1'b1;
          we_n    = 1'b1;
          maddr_n = addr;
          wdata_n = result[DATA_W-1:0];
          hi_n    = result[2*DATA_W-1:DATA_W];
          state_n = ST_LO;
        end else if (load) begin
          req_n   = 1'b1;
          we_n    = 1'b0;
          maddr_n = addr;
          state_n = LD;
        end
      end
      LD: begin
        if (mem.mem_resp) begin
          data_n  = mem.mem_rdata;
          req_n   = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end else if (timeout) begin
          req_n   = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end
      end
      ST_LO: begin
        if (mem.mem_resp) begin
          req_n   = 1'b0;
          state_n = ST_GAP;
        end else if (timeout) begin
          req_n   = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end
      end
      ST_GAP: begin
        // maddr_q still holds the captured address from the low-byte write.
        req_n   = 1'b1;
        we_n    = 1'b1;
        maddr_n = maddr_q + 1'b1;
        wdata_n = hi_q;
        state_n = ST_HI;
      end
      ST_HI: begin
        if (mem.mem_resp || timeout) begin
          req_n   = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
      hi_q    <= '0;
    end else begin
      data_q  <= data_n;
      done_q  <= done_n;
      req_q   <= req_n;
      we_q    <= we_n;
      maddr_q <= maddr_n;
      wdata_q <= wdata_n;
      hi_q    <= hi_n;
    end
  end

  assign data          = data_q;
  assign mem_done      = done_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_interface_unit.sv
// Self-checking bench for mem_interface_unit: vector table plus reset/timeout
// sequences, with a memory model that scoreboards every bus transaction.
`timescale 1ns/1ps
module tb_mem_interface_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load, store;
  logic [13:0] addr;
  logic [15:0] result;
  logic [7:0]  data;
  logic        mem_done, mem_err;

  always #5 clk = ~clk;

  mem_interface_unit_if #(.ADDR_W(14), .DATA_W(8)) mbus ();

  mem_interface_unit #(
    .ADDR_W(14),
    .DATA_W(8)
`ifdef MIU_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .store    (store),
    .addr     (addr),
    .result   (result),
    .data     (data),
    .mem_done (mem_done),
    .mem_err  (mem_err),
    .mem      (mbus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        we;
    logic [13:0] a;
    logic [7:0]  wd;
  } txn_t;

  txn_t        exp_q[$];
  int          mem_waits = 0;
  logic [7:0]  mem_rd_val = 8'h00;
  int          wcnt = 0;
  int          done_cnt = 0;
  int          txn_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: responds after mem_waits wait cycles, checks each transaction.
  always @(negedge clk) begin
    if (!mbus.mem_req) begin
      mbus.mem_resp  = 1'b0;
      mbus.mem_rdata = ~mem_rd_val;
      wcnt = 0;
    end else if (!mbus.mem_resp) begin
      if (wcnt >= mem_waits) begin
        txn_t e;
        mbus.mem_resp  = 1'b1;
        mbus.mem_rdata = mem_rd_val;
        txn_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_txn: got we=%0b addr=0x%0h expected none",
                   mbus.mem_we, mbus.mem_addr);
        end else begin
          e = exp_q.pop_front();
          check("txn_we", {31'd0, mbus.mem_we}, {31'd0, e.we});
          check("txn_addr", {18'd0, mbus.mem_addr}, {18'd0, e.a});
          if (e.we) check("txn_wdata", {24'd0, mbus.mem_wdata}, {24'd0, e.wd});
        end
      end else begin
        wcnt++;
      end
    end
  end

  always @(negedge clk) if (mem_done) done_cnt++;

  typedef struct {
    bit          ld;
    bit          st;
    logic [13:0] a;
    logic [15:0] r;
    logic [7:0]  rd;
    int          waits;
    logic [7:0]  exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic push_expect(input vec_t v);
    txn_t t;
    if (v.st) begin
      t.we = 1'b1; t.a = v.a;         t.wd = v.r[7:0];  exp_q.push_back(t);
      t.we = 1'b1; t.a = v.a + 14'd1; t.wd = v.r[15:8]; exp_q.push_back(t);
    end else begin
      t.we = 1'b0; t.a = v.a; t.wd = 8'h00; exp_q.push_back(t);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    int d0;
    int t0;
    bit seen;
    @(negedge clk);
    mem_waits  = v.waits;
    mem_rd_val = v.rd;
    push_expect(v);
    d0 = done_cnt;
    t0 = txn_cnt;
    load   = v.ld;
    store  = v.st;
    addr   = v.a;
    result = v.r;
    @(posedge clk);
    #1;
    addr   = ~v.a;
    result = ~v.r;
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 200 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (mem_done) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    load  = 1'b0;
    store = 1'b0;
    check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d_data", idx), {24'd0, data}, {24'd0, v.exp_data});
    check($sformatf("v%0d_err", idx), {31'd0, mem_err}, 32'd0);
    @(posedge clk);
    #1;
    check($sformatf("v%0d_done_width", idx), {31'd0, mem_done}, 32'd0);
    check($sformatf("v%0d_done_count", idx), done_cnt - d0, 1);
    check($sformatf("v%0d_txn_count", idx), txn_cnt - t0, v.st ? 2 : 1);
    check($sformatf("v%0d_queue_empty", idx), exp_q.size(), 0);
  endtask

  task automatic start_load(input logic [13:0] a);
    @(negedge clk);
    mem_waits  = 1000;
    mem_rd_val = 8'h66;
    load = 1'b1;
    addr = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d0;
    int lat;
    bit seen;
    //          ld    st    addr      result    rdata  waits data   lat
    vecs[0] = '{1'b1, 1'b0, 14'h0010, 16'h0000, 8'hA5, 0,    8'hA5, 1};
    vecs[1] = '{1'b0, 1'b1, 14'h0012, 16'hBEEF, 8'h11, 2,    8'hA5, 7};
    vecs[2] = '{1'b0, 1'b1, 14'h3FFF, 16'h1234, 8'h22, 0,    8'hA5, 3};
    vecs[3] = '{1'b1, 1'b1, 14'h0100, 16'hCAFE, 8'h77, 1,    8'hA5, 5};
    vecs[4] = '{1'b1, 1'b0, 14'h3FFF, 16'h0000, 8'h3C, 3,    8'h3C, 4};
    vecs[5] = '{1'b1, 1'b0, 14'h0000, 16'h0000, 8'h00, 0,    8'h00, 1};
    vecs[6] = '{1'b0, 1'b1, 14'h0000, 16'hFF01, 8'h33, 1,    8'h00, 5};
    vecs[7] = '{1'b1, 1'b0, 14'h2AAA, 16'h0000, 8'hFF, 0,    8'hFF, 1};
    vecs[8] = '{1'b1, 1'b0, 14'h0001, 16'h0000, 8'h99, 0,    8'h99, 1};

    mbus.mem_resp  = 1'b0;
    mbus.mem_rdata = 8'h00;
    load = 1'b0; store = 1'b0; addr = '0; result = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #2;
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_done", {31'd0, mem_done}, 32'd0);
    check("rst_err", {31'd0, mem_err}, 32'd0);
    check("rst_req", {31'd0, mbus.mem_req}, 32'd0);
    check("rst_we", {31'd0, mbus.mem_we}, 32'd0);
    check("rst_addr", {18'd0, mbus.mem_addr}, 32'd0);
    check("rst_wdata", {24'd0, mbus.mem_wdata}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Memory never answers: timeout build aborts, default build keeps waiting.
    d0 = done_cnt;
    start_load(14'h0055);
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (mem_done) begin
        seen = 1'b1;
        lat  = k;
        check("to_err_with_done", {31'd0, mem_err}, 32'd1);
      end
    end
`ifdef MIU_TIMEOUT_EN
    check("to_latency", lat, 8);
    check("to_data_kept", {24'd0, data}, 32'h0000_00FF);
    load = 1'b0;
    @(posedge clk);
    #1;
    check("to_err_cleared", {31'd0, mem_err}, 32'd0);
    check("to_req_dropped", {31'd0, mbus.mem_req}, 32'd0);
    d0 = done_cnt;
    start_load(14'h0056);
    repeat (3) @(posedge clk);
`else
    check("nto_no_done", {31'd0, seen}, 32'd0);
    check("nto_req_held", {31'd0, mbus.mem_req}, 32'd1);
    check("nto_err_low", {31'd0, mem_err}, 32'd0);
`endif

    // Reset in the middle of a load wait.
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_req", {31'd0, mbus.mem_req}, 32'd0);
    check("midrst_data", {24'd0, data}, 32'd0);
    check("midrst_done", {31'd0, mem_done}, 32'd0);
    load = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_idle_req", {31'd0, mbus.mem_req}, 32'd0);

    run_vec(8, vecs[8]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
